pixel_packer: RTL and testbench



---
 rtl/pixel_packer.sv | 84 ++++++++
 tb/tb_pixel_packer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pixel_packer.sv
// pixel_packer: packs FWFT 8-bit pixels little-endian into 32-bit words, zero-pads each frame's last word, pulses frame_done and counts frames (ports: clock, reset, in_rd_en/in_empty/in_dout, out_wr_en/out_full/out_din, frame_done, frame_count)
module pixel_packer #(
  parameter int WIDTH = 720,
  parameter int HEIGHT = 540,
  parameter int PIX_PER_WORD = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [7:0]  in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [31:0] out_din,
  output logic        frame_done,
  output logic [15:0] frame_count
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW = $clog2(NPIX) > 20 ? $clog2(NPIX) : 20;
  localparam int LW = PIX_PER_WORD > 1 ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(PIX_PER_WORD - 1);
  typedef enum logic {S_COLLECT, S_WRITE} state_t;
  state_t state, state_n;
  logic [31:0] word_reg, word_n;
  logic [LW-1:0] lane, lane_n;
  logic [CW-1:0] pix_cnt, cnt_n;
  logic last_flag, last_n, done_n;
  logic [15:0] fc_n;
  assign out_din = word_reg;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_COLLECT;
      word_reg <= '0;
      lane <= '0;
      pix_cnt <= '0;
      last_flag <= 1'b0;
      frame_done <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      word_reg <= word_n;
      lane <= lane_n;
      pix_cnt <= cnt_n;
      last_flag <= last_n;
      frame_done <= done_n;
      frame_count <= fc_n;
    end
  end
  always_comb begin
    state_n = state;
    word_n = word_reg;
    lane_n = lane;
    cnt_n = pix_cnt;
    last_n = last_flag;
    done_n = 1'b0;
    fc_n = frame_count;
    in_rd_en = state == S_COLLECT && !in_empty;
    out_wr_en = state == S_WRITE && !out_full;
    if (in_rd_en) begin
      word_n[{lane, 3'b000} +: 8] = in_dout;
      if (pix_cnt == LAST_PIX) begin
        last_n = 1'b1;
        cnt_n = '0;
        state_n = S_WRITE;
      end else if (lane == LAST_LANE) begin
        cnt_n = pix_cnt + 1'b1;
        state_n = S_WRITE;
      end else begin
        lane_n = lane + 1'b1;
        cnt_n = pix_cnt + 1'b1;
      end
    end
    // zeroing on accept is what pads the unused upper lanes of a frame's final word
    if (out_wr_en) begin
      word_n = '0;
      lane_n = '0;
      state_n = S_COLLECT;
      last_n = 1'b0;
      done_n = last_flag;
      fc_n = frame_count + 16'(last_flag);
    end
  end
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: randomized self-checking bench for pixel_packer against a frame/word-level reference model
module tb_pixel_packer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] in_empty = '1;
  logic [2:0] out_full = '0;
  logic [7:0] in_dout [3];
  logic [2:0] in_rd_en, out_wr_en, frame_done;
  logic [31:0] out_din [3];
  logic [15:0] frame_count [3];
  int cw [3] = '{4, 5, 2};
  int ch [3] = '{2, 3, 1};
  int cp [3] = '{4, 4, 1};
  int fc_exp [3] = '{0, 0, 0};
  logic [7:0] src [$];
  logic [31:0] got_w [$];
  int n_tests = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  pixel_packer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_WORD(4)) u0 (
    .clock(clock), .reset(reset), .in_rd_en(in_rd_en[0]), .in_empty(in_empty[0]), .in_dout(in_dout[0]),
    .out_wr_en(out_wr_en[0]), .out_full(out_full[0]), .out_din(out_din[0]),
    .frame_done(frame_done[0]), .frame_count(frame_count[0]));
  pixel_packer #(.WIDTH(5), .HEIGHT(3), .PIX_PER_WORD(4)) u1 (
    .clock(clock), .reset(reset), .in_rd_en(in_rd_en[1]), .in_empty(in_empty[1]), .in_dout(in_dout[1]),
    .out_wr_en(out_wr_en[1]), .out_full(out_full[1]), .out_din(out_din[1]),
    .frame_done(frame_done[1]), .frame_count(frame_count[1]));
  pixel_packer #(.WIDTH(2), .HEIGHT(1), .PIX_PER_WORD(1)) u2 (
    .clock(clock), .reset(reset), .in_rd_en(in_rd_en[2]), .in_empty(in_empty[2]), .in_dout(in_dout[2]),
    .out_wr_en(out_wr_en[2]), .out_full(out_full[2]), .out_din(out_din[2]),
    .frame_done(frame_done[2]), .frame_count(frame_count[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_idle(input int s, input string tag);
    check({tag, "_wr_en"}, 32'(out_wr_en[s]), 0);
    check({tag, "_din"}, out_din[s], 0);
    check({tag, "_done"}, 32'(frame_done[s]), 0);
    check({tag, "_count"}, 32'(frame_count[s]), 0);
    check({tag, "_rd_en"}, 32'(in_rd_en[s]), 0);
  endtask
  // streams src into instance s for nfr frames; the model knows how many words the
  // consumed pixels have completed, so it knows when a word must be on offer
  task automatic run(input int s, input int nfr, input int empty_pct, input int full_pct, input int hold);
    int npix, p, wpf, consumed, written, dones, hold_cnt, cyc, pend;
    bit done_pend;
    logic [31:0] exp_w [$];
    logic [31:0] w;
    npix = cw[s] * ch[s];
    p = cp[s];
    wpf = (npix + p - 1) / p;
    consumed = 0; written = 0; dones = 0; hold_cnt = 0; cyc = 0; done_pend = 0;
    got_w.delete();
    for (int f = 0; f < nfr; f++)
      for (int k = 0; k < wpf; k++) begin
        w = 0;
        for (int j = 0; j < p; j++)
          if (k * p + j < npix) w |= 32'(src[f * npix + k * p + j]) << (8 * j);
        exp_w.push_back(w);
      end
    while (written < exp_w.size() && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      pend = (consumed / npix) * wpf + (consumed % npix) / p - written;
      in_empty[s] = consumed >= src.size() || $urandom_range(99) < empty_pct;
      in_dout[s] = consumed < src.size() ? src[consumed] : 8'($urandom);
      out_full[s] = (pend > 0 && hold_cnt < hold) || $urandom_range(99) < full_pct;
      #1;
      if (frame_done[s] || done_pend) begin
        check("frame_done", 32'(frame_done[s]), 32'(done_pend));
        dones += int'(frame_done[s]);
      end
      done_pend = 0;
      if (pend > 0) begin
        check("rd_en_while_writing", 32'(in_rd_en[s]), 0);
        check("out_din", out_din[s], exp_w[written]);
        check("out_wr_en", 32'(out_wr_en[s]), 32'(!out_full[s]));
        if (out_full[s]) hold_cnt++;
        else begin
          got_w.push_back(out_din[s]);
          written++;
          hold_cnt = 0;
          if (written % wpf == 0) begin
            done_pend = 1;
            fc_exp[s] = (fc_exp[s] + 1) & 32'hFFFF;
          end
        end
      end else begin
        check("in_rd_en", 32'(in_rd_en[s]), 32'(!in_empty[s]));
        check("wr_en_idle", 32'(out_wr_en[s]), 0);
        if (!in_empty[s]) consumed++;
      end
    end
    if (written < exp_w.size()) check("timeout_words", 32'(written), 32'(exp_w.size()));
    @(negedge clock);
    in_empty[s] = 1'b1;
    out_full[s] = 1'b0;
    #1;
    if (frame_done[s] || done_pend) begin
      check("frame_done", 32'(frame_done[s]), 32'(done_pend));
      dones += int'(frame_done[s]);
    end
    check("frame_count", 32'(frame_count[s]), 32'(fc_exp[s]));
    check("done_pulses", 32'(dones), 32'(nfr));
    @(negedge clock);
    #1 check("done_clear", 32'(frame_done[s]), 0);
    src.delete();
  endtask
  task automatic rand_src(input int n);
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask
  initial begin
    int cnt;
    for (int s = 0; s < 3; s++) in_dout[s] = 8'h00;
    repeat (3) @(negedge clock);
    #1;
    for (int s = 0; s < 3; s++) check_idle(s, "reset");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) src.push_back(8'(i));
    run(0, 1, 0, 0, 0);
    check("normal_nwords", 32'(got_w.size()), 2);
    check("normal_w0", got_w[0], 32'h04030201);
    check("normal_w1", got_w[1], 32'h08070605);
    check("normal_count", 32'(frame_count[0]), 1);
    rand_src(32);
    run(0, 4, 30, 30, 0);
    for (int i = 'h10; i <= 'h1E; i++) src.push_back(8'(i));
    run(1, 1, 0, 0, 0);
    check("partial_nwords", 32'(got_w.size()), 4);
    check("partial_last", got_w[3], 32'h001E1D1C);
    check("partial_count", 32'(frame_count[1]), 1);
    rand_src(15);
    run(1, 1, 0, 0, 10);
    check("bp_count", 32'(frame_count[1]), 2);
    rand_src(45);
    run(1, 3, 50, 20, 0);
    check("starve_nwords", 32'(got_w.size()), 12);
    check("starve_count", 32'(frame_count[1]), 5);
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 6; c++) begin
      @(negedge clock);
      in_empty[1] = 1'b0;
      in_dout[1] = 8'($urandom);
      #1 if (in_rd_en[1]) cnt++;
    end
    check("pre_reset_pixels", 32'(cnt), 6);
    @(negedge clock);
    in_empty[1] = 1'b1;
    reset = 1'b1;
    #1 check_idle(1, "midreset");
    @(negedge clock);
    #1 check_idle(1, "midreset_hold");
    reset = 1'b0;
    fc_exp = '{0, 0, 0};
    rand_src(15);
    run(1, 1, 30, 0, 0);
    check("after_reset_nwords", 32'(got_w.size()), 4);
    check("after_reset_count", 32'(frame_count[1]), 1);
    @(negedge clock);
    force u2.frame_count = 16'hFFFF;
    @(negedge clock);
    release u2.frame_count;
    #1 check("wrap_preset", 32'(frame_count[2]), 32'hFFFF);
    fc_exp[2] = 32'hFFFF;
    src.push_back(8'hAA);
    src.push_back(8'hBB);
    run(2, 1, 0, 0, 0);
    check("wrap_w0", got_w[0], 32'h000000AA);
    check("wrap_w1", got_w[1], 32'h000000BB);
    check("wrap_count", 32'(frame_count[2]), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
